// File: rtl/tank_level_monitor_if.sv
// Probe inputs and level flags exchanged between the tank probes and the fertilising controller.
// The monitor itself connects through the slave modport.
interface tank_level_if;
  logic       probe_top;
  logic       probe_mid;
  logic       probe_bottom;
  logic       fault_clear;
  logic       critical_level;
  logic       empty_tank;
  logic       full_tank;
  logic [2:0] level_state;
  logic       fault;

  modport master (
    output probe_top,
    output probe_mid,
    output probe_bottom,
    output fault_clear,
    input  critical_level,
    input  empty_tank,
    input  full_tank,
    input  level_state,
    input  fault
  );

  modport slave (
    input  probe_top,
    input  probe_mid,
    input  probe_bottom,
    input  fault_clear,
    output critical_level,
    output empty_tank,
    output full_tank,
    output level_state,
    output fault
  );
endinterface

// File: rtl/tank_level_monitor.sv
// Tank level monitor: 2-flop probe sync, per-probe debounce, level FSM with refill hysteresis.
// Optional sensor-consistency FAULT state is enabled by defining TANK_SENSOR_FAULT_EN.
module tank_level_monitor #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REFILL_HOLD     = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  tank_level_if.slave bus
);

  typedef enum logic [2:0] {
    ST_EMPTY    = 3'd0,
    ST_CRITICAL = 3'd1,
    ST_NORMAL   = 3'd2,
    ST_FULL     = 3'd3,
    ST_FAULT    = 3'd4
  } level_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REFILL_HOLD - 1);

  // Probe vector order: bit 0 = bottom, bit 1 = mid, bit 2 = top.
  logic [2:0] raw_probes;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] filt_probes;

  assign raw_probes = {bus.probe_top, bus.probe_mid, bus.probe_bottom};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_probes;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_probe
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             filt_q;
      logic             filt_d;

      // Any sample agreeing with the filtered value restarts the stability run.
      always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q[gi] == filt_q) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          filt_d = sync2_q[gi];
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign filt_probes[gi] = filt_q;
    end
  endgenerate

  // Pessimistic decode: the lowest dry probe decides the level.
  level_t target;
  always_comb begin
    target = ST_FULL;
    if (!filt_probes[0]) begin
      target = ST_EMPTY;
    end else if (!filt_probes[1]) begin
      target = ST_CRITICAL;
    end else if (!filt_probes[2]) begin
      target = ST_NORMAL;
    end
  end

  level_t           state_q;
  level_t           state_d;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;

`ifdef TANK_SENSOR_FAULT_EN
  logic inconsistent;
  assign inconsistent = (filt_probes[2] & ~filt_probes[1]) |
                        (filt_probes[1] & ~filt_probes[0]);
`else
  logic unused_fault_clear;
  assign unused_fault_clear = bus.fault_clear;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
`ifdef TANK_SENSOR_FAULT_EN
    if (inconsistent) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (bus.fault_clear) begin
        state_d = target;
      end
    end else
`endif
    begin
      // Falling levels act at once; rising levels must persist for the hold time.
      if (target < state_q) begin
        state_d = target;
      end else if (target > state_q) begin
        if (hold_q == HOLD_LAST) begin
          state_d = target;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.level_state    = state_q;
  assign bus.full_tank      = (state_q == ST_FULL);
  assign bus.critical_level = (state_q == ST_EMPTY) || (state_q == ST_CRITICAL) ||
                              (state_q == ST_FAULT);
  assign bus.empty_tank     = (state_q == ST_EMPTY) || (state_q == ST_FAULT);
`ifdef TANK_SENSOR_FAULT_EN
  assign bus.fault          = (state_q == ST_FAULT);
`else
  assign bus.fault          = 1'b0;
`endif

endmodule

// File: tb/tb_tank_level_monitor.sv
// Randomised and directed bench for tank_level_monitor with a scoreboard fed by a
// window-based reference model of the probe filters and level hysteresis.
module tb_tank_level_monitor;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tank_level_if bus_if();

  tank_level_monitor #(
    .DEBOUNCE_CYCLES(DEB),
    .REFILL_HOLD    (HOLD),
    .CNT_W          (8)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus_if)
  );

  // Expected {level_state, critical_level, empty_tank, full_tank, fault}
  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: history of raw samples taken at each clock edge.
  bit [2:0] hist[$];
  bit [2:0] m_filt;
  int       m_state;
  int       m_run;

  function automatic int decode(bit [2:0] f);
    if (!f[0]) return 0;
    if (!f[1]) return 1;
    if (!f[2]) return 2;
    return 3;
  endfunction

  function automatic bit consistent(bit [2:0] f);
    return !((f[2] && !f[1]) || (f[1] && !f[0]));
  endfunction

  function automatic logic [6:0] expected_outputs(int s);
    logic [6:0] e;
    e[6:4] = 3'(s);
    e[3]   = (s == 0) || (s == 1) || (s == 4);
    e[2]   = (s == 0) || (s == 4);
    e[1]   = (s == 3);
    e[0]   = (s == 4);
    return e;
  endfunction

  task automatic model_edge(bit rst, bit [2:0] raw, bit clr);
    int       tgt;
    bit [2:0] nf;
    bit       flip;
    if (!rst) begin
      m_filt  = 3'b000;
      m_state = 0;
      m_run   = 0;
      // Reset clears both sync stages: the last two synced samples read as 0.
      if (hist.size() > 0) hist[hist.size()-1] = 3'b000;
      hist.push_back(3'b000);
    end else begin
      tgt = decode(m_filt);
`ifdef TANK_SENSOR_FAULT_EN
      if (!consistent(m_filt)) begin
        m_state = 4;
        m_run   = 0;
      end else if (m_state == 4) begin
        if (clr) m_state = tgt;
        m_run = 0;
      end else
`endif
      begin
        if (tgt <= m_state) begin
          m_state = (tgt < m_state) ? tgt : m_state;
          m_run   = 0;
        end else begin
          m_run++;
          if (m_run == HOLD) begin
            m_state = tgt;
            m_run   = 0;
          end
        end
      end
      // A probe's filtered value flips once the last DEB synced samples all disagree with it.
      nf = m_filt;
      for (int p = 0; p < 3; p++) begin
        flip = (hist.size() >= DEB + 1);
        for (int j = 0; j < DEB; j++) begin
          if (flip && hist[hist.size()-2-j][p] == m_filt[p]) flip = 1'b0;
        end
        if (flip) nf[p] = ~m_filt[p];
      end
      m_filt = nf;
      hist.push_back(raw);
    end
  endtask

  task automatic step(bit rst, bit top, bit mid, bit bot, bit clr);
    rst_n               = rst;
    bus_if.probe_top    = top;
    bus_if.probe_mid    = mid;
    bus_if.probe_bottom = bot;
    bus_if.fault_clear  = clr;
    model_edge(rst, {top, mid, bot}, clr);
    exp_q.push_back(expected_outputs(m_state));
    @(negedge clk);
  endtask

  task automatic hold_steps(int n, bit top, bit mid, bit bot);
    for (int i = 0; i < n; i++) step(1'b1, top, mid, bot, 1'b0);
  endtask

  task automatic chk(string nm, int got, int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, want);
  endtask

  // Monitor: one scoreboard comparison after every clock edge.
  initial begin
    logic [6:0] e;
    logic [6:0] got;
    forever begin
      @(posedge clk);
      #1;
      got = {bus_if.level_state, bus_if.critical_level, bus_if.empty_tank,
             bus_if.full_tank, bus_if.fault};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow: got %b expected an entry", got);
      end else begin
        e = exp_q.pop_front();
        if (got === e) begin
          n_pass++;
        end else begin
          $display("FAIL scoreboard t=%0t: got lvl=%0d crit=%b empty=%b full=%b fault=%b expected lvl=%0d crit=%b empty=%b full=%b fault=%b",
                   $time, got[6:4], got[3], got[2], got[1], got[0],
                   e[6:4], e[3], e[2], e[1], e[0]);
        end
      end
      $display("txn t=%0t lvl=%0d crit=%b empty=%b full=%b fault=%b", $time,
               got[6:4], got[3], got[2], got[1], got[0]);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int dur;
    bit [2:0] pr;
    bit rr;

    // Reset with all probes wet.
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset_level", bus_if.level_state, 0);
    chk("reset_critical", bus_if.critical_level, 1);
    chk("reset_empty", bus_if.empty_tank, 1);
    chk("reset_full", bus_if.full_tank, 0);
    chk("reset_fault", bus_if.fault, 0);

    // Refill to FULL: 2 sync + 4 debounce + 8 hold edges.
    hold_steps(13, 1, 1, 1);
    chk("fill_edge13_level", bus_if.level_state, 0);
    hold_steps(1, 1, 1, 1);
    chk("fill_edge14_level", bus_if.level_state, 3);
    chk("fill_full", bus_if.full_tank, 1);
    chk("fill_critical", bus_if.critical_level, 0);

    // Glitchy drop of mid/top must be rejected.
    for (int r = 0; r < 5; r++) begin
      hold_steps(2, 0, 0, 1);
      hold_steps(1, 1, 1, 1);
    end
    chk("glitch_level", bus_if.level_state, 3);
    hold_steps(6, 0, 0, 1);
    chk("drop_edge6_level", bus_if.level_state, 3);
    hold_steps(1, 0, 0, 1);
    chk("drop_edge7_level", bus_if.level_state, 1);
    chk("drop_critical", bus_if.critical_level, 1);
    chk("drop_empty", bus_if.empty_tank, 0);

    // Short mid pulse is filtered but too short to finish the refill hold.
    hold_steps(5, 0, 1, 1);
    hold_steps(12, 0, 0, 1);
    chk("pulse_level", bus_if.level_state, 1);
    hold_steps(13, 0, 1, 1);
    chk("rise_edge13_level", bus_if.level_state, 1);
    hold_steps(1, 0, 1, 1);
    chk("rise_edge14_level", bus_if.level_state, 2);

    // Fast drop to EMPTY.
    hold_steps(6, 0, 0, 0);
    chk("empty_edge6_level", bus_if.level_state, 2);
    hold_steps(1, 0, 0, 0);
    chk("empty_edge7_level", bus_if.level_state, 0);
    chk("empty_flag", bus_if.empty_tank, 1);

    // Reset in the middle of a refill discards the hold progress.
    hold_steps(10, 1, 1, 1);
    chk("midrefill_level", bus_if.level_state, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("midrefill_reset_level", bus_if.level_state, 0);
    hold_steps(13, 1, 1, 1);
    chk("refill_restart_edge13", bus_if.level_state, 0);
    hold_steps(1, 1, 1, 1);
    chk("refill_restart_edge14", bus_if.level_state, 3);

    // Inconsistent probe combination: top wet, mid dry.
    hold_steps(7, 1, 0, 1);
`ifdef TANK_SENSOR_FAULT_EN
    chk("incons_level", bus_if.level_state, 4);
    chk("incons_fault", bus_if.fault, 1);
    chk("incons_full", bus_if.full_tank, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clear_ignored_level", bus_if.level_state, 4);
    hold_steps(8, 1, 1, 1);
    chk("consistent_still_fault", bus_if.level_state, 4);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear_to_full", bus_if.level_state, 3);
    chk("clear_fault_flag", bus_if.fault, 0);
`else
    chk("incons_level", bus_if.level_state, 1);
    chk("incons_fault", bus_if.fault, 0);
    chk("incons_critical", bus_if.critical_level, 1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clear_noeffect_level", bus_if.level_state, 1);
    hold_steps(8, 1, 1, 1);
    chk("consistent_holding", bus_if.level_state, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear_no_skip_hold", bus_if.level_state, 1);
    chk("clear_fault_flag", bus_if.fault, 0);
`endif

    // Randomised probe segments with occasional resets and clear requests.
    for (int s = 0; s < 150; s++) begin
      pr  = 3'($urandom_range(0, 7));
      dur = $urandom_range(1, 20);
      for (int i = 0; i < dur; i++) begin
        rr = ($urandom_range(0, 79) != 0);
        step(rr, pr[2], pr[1], pr[0], ($urandom_range(0, 3) == 0));
      end
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
